// File: rtl/signed_booth_multiplier.sv
// Sequential radix-2 Booth multiplier for two's-complement operands.
// One Booth step per clock; WIDTH steps per product; start/busy/done handshake.
module signed_booth_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] m, m_next;
  logic [WIDTH-1:0] q, q_next;
  logic [AW-1:0]    acc, acc_next;
  logic             q_1, q1_next;
  logic [CW-1:0]    count, count_next;
  logic [PW-1:0]    product_next;
  logic             busy_next;
  logic             done_next;

  // Booth datapath intermediates: extended multiplicand, add/sub result, shifted pair
  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    acc_sh;
  logic [WIDTH-1:0] q_sh;

  // State and datapath registers; synchronous reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      m       <= m_next;
      q       <= q_next;
      acc     <= acc_next;
      q_1     <= q1_next;
      count   <= count_next;
      product <= product_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // Next-state and Booth step; acc is one bit wider so subtracting the most negative M cannot overflow
  always_comb begin
    state_next   = state;
    m_next       = m;
    q_next       = q;
    acc_next     = acc;
    q1_next      = q_1;
    count_next   = count;
    product_next = product;
    busy_next    = busy;
    done_next    = 1'b0;

    addend = {m[WIDTH-1], m};
    case ({q[0], q_1})
      2'b01:   sum = acc + addend;
      2'b10:   sum = acc - addend;
      default: sum = acc;
    endcase
    acc_sh = {sum[AW-1], sum[AW-1:1]};
    q_sh   = {sum[0], q[WIDTH-1:1]};

    case (state)
      IDLE: begin
        if (start) begin
          m_next     = A;
          q_next     = B;
          acc_next   = '0;
          q1_next    = 1'b0;
          count_next = CW'(WIDTH);
          busy_next  = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        acc_next   = acc_sh;
        q_next     = q_sh;
        q1_next    = q[0];
        count_next = count - CW'(1);
        if (count == CW'(1)) begin
          product_next = {acc_sh[WIDTH-1:0], q_sh};
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_signed_booth_multiplier.sv
// Directed self-checking bench for signed_booth_multiplier (WIDTH=8).
module tb_signed_booth_multiplier;

  localparam int unsigned W = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [2*W-1:0] product;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  signed_booth_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (a_in),
    .B       (b_in),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start for one edge; returns just after the accepting edge
  task automatic do_op(input int a, input int b);
    a_in  = W'(a);
    b_in  = W'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Advance cycles until done is seen (bounded); lat = edges after acceptance
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_signed();
    int va[4] = '{13, 20, -18, -21};
    int vb[4] = '{3, -4, 3, -7};
    logic [15:0] ve[4] = '{16'h0027, 16'hFFB0, 16'hFFCA, 16'h0093};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i]);
      wait_done(lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL signed_latency[%0d] got=%0d exp=8", i, lat); end
      checks++; if (product !== ve[i]) begin errors++; $display("FAIL signed_product[%0d] got=%h exp=%h", i, product, ve[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_extremes();
    int va[3] = '{-128, -128, 0};
    int vb[3] = '{-128, 127, -6};
    logic [15:0] ve[3] = '{16'h4000, 16'hC080, 16'h0000};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i]);
      wait_done(lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL extreme_latency[%0d] got=%0d exp=8", i, lat); end
      checks++; if (product !== ve[i]) begin errors++; $display("FAIL extreme_product[%0d] got=%h exp=%h", i, product, ve[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_handshake();
    int busy_cnt = 0;
    int cyc = 0;
    do_op(5, 9);
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if (cyc == 2) begin
        start = 1'b1; a_in = 8'd7; b_in = 8'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL hs_busy_cycles got=%0d exp=8", busy_cnt); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL hs_latency got=%0d exp=8", cyc); end
    checks++; if (product !== 16'h002D) begin errors++; $display("FAIL hs_product got=%h exp=002d", product); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hs_done_width got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(6, -5);
    wait_done(lat);
    checks++; if (product !== 16'hFFE2) begin errors++; $display("FAIL b2b_first_product got=%h exp=ffe2", product); end
    // Start issued while done is high
    do_op(-1, -1);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got done=%b busy=%b exp done=0 busy=1", done, busy); end
    wait_done(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
    checks++; if (product !== 16'h0001) begin errors++; $display("FAIL b2b_second_product got=%h exp=0001", product); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    do_op(13, 3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_state got product=%h busy=%b done=%b exp 0000/0/0", product, busy, done);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d pulses exp=0", seen); end
    do_op(2, 3);
    wait_done(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_latency got=%0d exp=8", lat); end
    checks++; if (product !== 16'h0006) begin errors++; $display("FAIL midrst_product got=%h exp=0006", product); end
  endtask

  task automatic test_hold();
    int done_seen = 0;
    int changed = 0;
    for (int i = 0; i < 20; i++) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
      @(posedge clk); #1;
      if (done) done_seen++;
      if (product !== 16'h0006) changed++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL hold_done got=%0d exp=0", done_seen); end
    checks++; if (changed !== 0) begin errors++; $display("FAIL hold_product got=%0d changes product=%h exp=0006", changed, product); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_extremes();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
